// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the RV32M divide sequencer.
package div_pkg;

  localparam int DEFAULT_XLEN = 32;

  // Iteration counter width: large enough to hold the value XLEN.
  localparam int CNT_W = $clog2(DEFAULT_XLEN + 1);

  // Architectural corner results at the default width.
  localparam logic [DEFAULT_XLEN-1:0] DIV_ZERO_Q = {DEFAULT_XLEN{1'b1}};
  localparam logic [DEFAULT_XLEN-1:0] DIV_OVF_Q  = {1'b1, {(DEFAULT_XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
// Shifts {rem, quo} left by one, trial-subtracts the divisor and keeps the
// difference only when it does not borrow.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   shifted;
  logic            borrow;
  logic [XLEN-1:0] diff;

  // The partial remainder is always below the divisor, so the shifted value
  // needs one extra bit only for the comparison; a non-borrowing difference
  // always fits back into XLEN bits.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign borrow  = shifted < {1'b0, divisor_i};
  assign diff    = shifted[XLEN-1:0] - divisor_i;

  assign rem_o = borrow ? shifted[XLEN-1:0] : diff;
  assign quo_o = {quo_i[XLEN-2:0], ~borrow};

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIV/DIVU/REM/REMU controller for the EX stage.
// Holds the pipeline with stall while a restoring divide runs, applies the
// RISC-V sign rules, then releases EX for one cycle with done and result.
// Optional build macro DIV_FASTPATH_EN: zero divisor, signed overflow,
// divide-by-one and unsigned dividend<divisor finish straight from IDLE.
module div_sequencer
  import div_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            signed_div,
  input  logic            rem_sel,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  div_state_t      state_q, state_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            div_zero_q, div_zero_d;
  logic [XLEN-1:0] quotient_q, quotient_d;
  logic [XLEN-1:0] remainder_q, remainder_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            dvd_neg, dvs_neg;
  logic [XLEN-1:0] abs_dvd, abs_dvs;
  logic [XLEN-1:0] step_rem, step_quo;

  // Magnitudes are taken only for signed ops; unsigned ops pass raw values.
  assign dvd_neg = signed_div & dividend[XLEN-1];
  assign dvs_neg = signed_div & divisor[XLEN-1];
  assign abs_dvd = dvd_neg ? -dividend : dividend;
  assign abs_dvs = dvs_neg ? -divisor  : divisor;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

`ifdef DIV_FASTPATH_EN
  localparam logic [XLEN-1:0] ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] OVF_Q  = {1'b1, {(XLEN-1){1'b0}}};

  logic            fast_hit;
  logic [XLEN-1:0] fast_q, fast_r;

  // Detect operand pairs whose result is known without iterating.
  always_comb begin
    fast_hit = 1'b0;
    fast_q   = '0;
    fast_r   = '0;
    if (divisor == '0) begin
      fast_hit = 1'b1;
      fast_q   = ZERO_Q;
      fast_r   = dividend;
    end else if (signed_div && dividend == OVF_Q && divisor == '1) begin
      fast_hit = 1'b1;
      fast_q   = OVF_Q;
    end else if (divisor == XLEN'(1)) begin
      fast_hit = 1'b1;
      fast_q   = dividend;
    end else if (!signed_div && dividend < divisor) begin
      fast_hit = 1'b1;
      fast_r   = dividend;
    end
  end
`endif

  // Next-state and datapath update for the IDLE/ITER/FIXUP/DONE sequence.
  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves a variable unassigned, which would infer a latch.
    state_d     = state_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    div_zero_d  = div_zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    if (flush) begin
      // A redirect kills the op; the visible results stay as they were.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            quo_d      = abs_dvd;
            dvs_d      = abs_dvs;
            rem_d      = '0;
            cnt_d      = '0;
            neg_quo_d  = dvd_neg ^ dvs_neg;
            neg_rem_d  = dvd_neg;
            div_zero_d = (divisor == '0);
            state_d    = ITER;
`ifdef DIV_FASTPATH_EN
            if (fast_hit) begin
              quotient_d  = fast_q;
              remainder_d = fast_r;
              state_d     = DONE;
            end
`endif
          end
        end
        ITER: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) state_d = FIXUP;
        end
        FIXUP: begin
          // A zero divisor must keep the all-ones quotient un-negated.
          quotient_d  = (neg_quo_q && !div_zero_q) ? -quo_q : quo_q;
          remainder_d = neg_rem_q ? -rem_q : rem_q;
          state_d     = DONE;
        end
        DONE: begin
          // start seen here still belongs to the retiring op.
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q     <= IDLE;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      div_zero_q  <= div_zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign stall     = reset & (((state_q == IDLE) & start) |
                              (state_q == ITER) | (state_q == FIXUP));
  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign result    = rem_sel ? remainder_q : quotient_q;

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller for the EX-stage integer divider serving RV32M DIV/DIVU/REM/REMU. It captures operands when EX presents a divide and holds the pipeline with `stall` while it runs a radix-2 restoring iteration. It then applies the RISC-V sign and corner-case rules and releases the stage for exactly one cycle with the result valid. It sits beside the ALU in EX, and EX's result mux consumes `result`.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; the iteration count equals `XLEN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; the block is in reset when `reset` is 0.
- `start`  in  1  level; EX holds a divide op and keeps the value stable while `stall` is 1.
- `signed_div`  in  1  1 selects DIV/REM, 0 selects DIVU/REMU.
- `rem_sel`  in  1  0 drives `result` from the quotient, 1 drives it from the remainder.
- `dividend`  in  XLEN  forwarded rs1 value.
- `divisor`  in  XLEN  forwarded rs2 value.
- `flush`  in  1  kills the op in flight (branch redirect).
- `stall`  out  1  combinational; holds IF/ID/EX and bubbles EX/MEM.
- `busy`  out  1  registered; 1 in any state other than IDLE.
- `done`  out  1  registered; one-cycle pulse, `result` valid.
- `quotient`  out  XLEN  registered; final signed-corrected quotient.
- `remainder`  out  XLEN  registered; final signed-corrected remainder.
- `result`  out  XLEN  `rem_sel ? remainder : quotient`.

## Operation
States: IDLE, ITER, FIXUP, DONE.

- **IDLE**
  - When `start`=1, latch |dividend| and |divisor|. Absolute value applies only when `signed_div`=1; otherwise the raw values are latched.
  - Also latch `neg_q` = sign(dividend) XOR sign(divisor), `neg_r` = sign(dividend), and `div_zero` = (divisor==0).
  - Clear the partial remainder and the counter, then go to ITER.
- **ITER**
  - Each cycle: shift {rem, quo} left by 1 and trial-subtract the divisor.
  - On no borrow, keep the difference and set the quotient LSB to 1.
  - The counter increments. After `XLEN` iterations, go to FIXUP.
- **FIXUP**
  - Negate the quotient if `neg_q` and not `div_zero`.
  - Negate the remainder if `neg_r`.
  - Register both, then go to DONE.
- **DONE**
  - `done`=1 and `stall`=0, so the pipeline advances and latches `result`.
  - Unconditionally go to IDLE. `start` seen in DONE belongs to the retiring op and is ignored.
- **`stall`**
  - `stall` = (state==IDLE & `start`) | state==ITER | state==FIXUP.
  - `stall` is forced to 0 while in reset.

Corner results, produced by the algorithm without special handling:
- Divide by zero: quotient = all ones, remainder = dividend.
- Signed overflow (−2^(XLEN−1) / −1): quotient = 0x8000_0000, remainder = 0.

Boundary conditions:
- `flush`=1 in any state: next state IDLE, no `done`, `quotient`/`remainder` unchanged. `flush` takes priority over `start` in IDLE.
- Reset mid-operation: next cycle state IDLE. All registered outputs and internal registers go to 0.
- Operands changing while `stall`=1 are ignored; only IDLE-cycle values are used.
- Back-to-back divides: the second op's `start` is first honoured in the IDLE cycle after DONE.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `result`=0, state=IDLE.
- The IDLE cycle with `start`=1 is cycle 0.
- ITER occupies cycles 1..XLEN, and FIXUP occupies cycle XLEN+1.
- DONE occupies cycle XLEN+2, which is 34 for XLEN=32.
- `stall` is high for cycles 0..XLEN+1, which is 34 cycles.
- Each divide therefore occupies EX for XLEN+3 cycles.
- `busy` rises at cycle 1 and falls the cycle after DONE.

## Configuration
- `DIV_FASTPATH_EN` defined:
  - In IDLE, a zero divisor or signed overflow skips ITER/FIXUP.
  - The corner result is loaded directly, and the next state is DONE.
  - `stall`=1 in cycle 0 and `done`=1 in cycle 1.
  - Divisions by 1 and unsigned operands with dividend < divisor also take the fast path: quotient = dividend or 0, remainder = 0 or dividend.
- Undefined: every divide takes the full XLEN+3 cycles. Results are identical either way.

## Structure
- Package `div_pkg`:
  - `div_state_t` enum (IDLE, ITER, FIXUP, DONE).
  - Default `XLEN`.
  - Counter width constant `CNT_W` = $clog2(XLEN+1).
  - Corner-case constants `DIV_ZERO_Q` (all ones) and `DIV_OVF_Q` (MSB only).
- Sub-module `div_step`: combinational single restoring iteration. It takes {rem, quo, divisor} and returns {rem_next, quo_next}. The sequencer instantiates it once.

## Test plan
- DIVU 100/7, `rem_sel`=0 → `stall` high 34 cycles; `done` at cycle 34 with `quotient`=14, `remainder`=2, `result`=14.
- DIV −100/7, `rem_sel`=1 → `quotient`=−14 (0xFFFF_FFF2), `remainder`=−2, `result`=0xFFFF_FFFE.
- DIV 0x8000_0000 / 0xFFFF_FFFF, and DIVU 5/0 → (0x8000_0000, 0) and (0xFFFF_FFFF, 5). With `DIV_FASTPATH_EN`, `done` arrives at cycle 1.
- `flush` at cycle 10 of DIVU 1000/3 → IDLE next cycle, no `done`, `stall` low. A following DIVU 9/3 then completes with `quotient`=3.
- `reset`=0 at cycle 20 mid-op → all outputs 0 next cycle, `busy`=0. After release, a new divide completes normally.
- Two DIVU ops back-to-back with `start` held through DONE → exactly two `done` pulses, 35 cycles apart, each with its own correct result.
